// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// latched request record and size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [7:0]  m8;      // byte lanes across the two touched words
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'h1;
            2'b01:   return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    // 1 -> 1 byte, 3 -> 2 bytes, F -> 4 bytes
    function automatic logic [2:0] size_bytes(input logic [3:0] m);
        return {m[2], m[1] & ~m[2], m[0] & ~m[1]};
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-side bus of the load/store unit.
// slave is the LSU view; master is the execute stage plus memory environment.
interface lsu_mem_ctrl_if #(parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [31:0]   mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic [3:0]    mem_wr_en;
    logic [31:0]   mem_rd_addr;
    logic [31:0]   mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_addr
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_addr
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Sizes right-justified raw load data and applies sign or zero extension.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);
    always_comb begin
        o_rdata = i_raw;
        case (i_funct3)
            F3_B:    o_rdata = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_H:    o_rdata = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_BU:   o_rdata = {24'h0, i_raw[7:0]};
            F3_HU:   o_rdata = {16'h0, i_raw[15:0]};
            default: o_rdata = i_raw;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a byte-enabled data memory. Word-crossing
// accesses are split into two memory cycles (ACC0 then ACC1).
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    lsu_state_t    r_state;
    lsu_req_t      r_req;
    logic [AW-3:0] r_waddr;
    logic [31:0]   r_raw;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;

    logic [3:0]    w_m;
    logic [7:0]    w_m8;
    logic [AW:0]   w_last;
    logic          w_bad;
    logic [31:0]   w_word0;
    logic [31:0]   w_word1;
    logic [4:0]    w_sh0;
    logic [5:0]    w_sh1;
    logic [31:0]   w_raw_nxt;
    logic [31:0]   w_ext;
    logic [31:0]   w_wr_addr;
    logic [31:0]   w_wr_data;
    logic [3:0]    w_wr_en;
    logic [31:0]   w_rd_addr;

    // Request decode, only meaningful in IDLE
    assign w_m    = size_mask(bus.req_funct3);
    assign w_m8   = {4'h0, w_m} << bus.req_addr[1:0];
    // One extra bit so an address near the top of the space cannot wrap
    assign w_last = {1'b0, bus.req_addr} + (AW+1)'(size_bytes(w_m)) - (AW+1)'(1);
    assign w_bad  = !f3_legal(bus.req_we, bus.req_funct3) ||
                    (w_last >= (AW+1)'(MEM_BYTES));

    assign w_word0 = 32'({r_waddr, 2'b00});
    assign w_word1 = w_word0 + 32'd4;
    assign w_sh0   = {r_req.off, 3'b000};
    assign w_sh1   = 6'd32 - {1'b0, r_req.off, 3'b000};

    // Memory side is decoded from state so reset kills writes immediately
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        w_wr_en   = '0;
        w_rd_addr = '0;
        w_raw_nxt = r_raw;
        case (r_state)
            ACC0: begin
                w_wr_addr = w_word0;
                w_rd_addr = w_word0;
                w_raw_nxt = bus.mem_rd_data >> w_sh0;
                if (r_req.we) begin
                    w_wr_en   = r_req.m8[3:0];
                    w_wr_data = r_req.wdata << w_sh0;
                end
            end
            ACC1: begin
                w_wr_addr = w_word1;
                w_rd_addr = w_word1;
                w_raw_nxt = r_raw | (bus.mem_rd_data << w_sh1);
                if (r_req.we) begin
                    w_wr_en   = r_req.m8[7:4];
                    w_wr_data = r_req.wdata >> w_sh1;
                end
            end
            default: ;
        endcase
    end

    lsu_load_extend u_ext (
        .i_raw    (w_raw_nxt),
        .i_funct3 (r_req.funct3),
        .o_rdata  (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_waddr     <= '0;
            r_raw       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    r_raw <= '0;
                    if (bus.req_valid) begin
                        r_req.we     <= bus.req_we;
                        r_req.funct3 <= bus.req_funct3;
                        r_req.off    <= bus.req_addr[1:0];
                        r_req.m8     <= w_m8;
                        r_req.wdata  <= bus.req_wdata;
                        r_waddr      <= bus.req_addr[AW-1:2];
                        if (w_bad) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    r_raw <= w_raw_nxt;
                    if (r_req.m8[7:4] != 4'h0) begin
                        r_state <= ACC1;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_req.we ? 32'h0 : w_ext;
                    end
                end
                ACC1: begin
                    r_raw       <= w_raw_nxt;
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_req.we ? 32'h0 : w_ext;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.mem_wr_addr = w_wr_addr;
    assign bus.mem_wr_data = w_wr_data;
    assign bus.mem_wr_en   = w_wr_en;
    assign bus.mem_rd_addr = w_rd_addr;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a byte-array memory model, a response
// scoreboard checked by an independent monitor, and memory-side probes.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int MEMB = 128;

    logic clk;
    logic rst_n;
    lsu_mem_ctrl_if #(.AW(32)) bus ();

    lsu_mem_ctrl #(.MEM_BYTES(MEMB), .AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      t_exp;
        int          tag;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         en_cnt = 0;
    logic [7:0] mem [MEMB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // Memory model: combinational read, byte-enabled synchronous write
    always_comb begin
        bus.mem_rd_data = 32'h0;
        if (int'(bus.mem_rd_addr) <= MEMB - 4)
            bus.mem_rd_data = mword(int'(bus.mem_rd_addr));
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.mem_wr_en[i] && (int'(bus.mem_wr_addr) + i < MEMB))
                mem[int'(bus.mem_wr_addr) + i] <= bus.mem_wr_data[8*i +: 8];
    end

    always @(negedge clk) if (bus.mem_wr_en != 4'h0) en_cnt++;

    // Response monitor
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            exp_t e;
            chk("rsp_with_ready", {31'h0, bus.req_ready}, 32'h0);
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("rsp%0d_rdata", e.tag), bus.rsp_rdata, e.rdata);
                chk($sformatf("rsp%0d_err", e.tag), {31'h0, bus.rsp_err}, {31'h0, e.err});
                chk($sformatf("rsp%0d_time", e.tag), 32'($time), 32'(e.t_exp));
            end
        end
    end

    task automatic do_req(input int tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int lat,
                          input bit push);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            chk($sformatf("req%0d_ready_timeout", tag), 32'h0, 32'h1);
            return;
        end
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.t_exp = longint'($time) + longint'((lat - 1) * 10 + 5);
            e.tag   = tag;
            sbq.push_back(e);
        end
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic chk_mem(input string nm, input logic [31:0] ad,
                           input logic [3:0] en, input logic [31:0] dat);
        chk({nm, "_wr_addr"}, bus.mem_wr_addr, ad);
        chk({nm, "_rd_addr"}, bus.mem_rd_addr, ad);
        chk({nm, "_wr_en"}, {28'h0, bus.mem_wr_en}, {28'h0, en});
        chk({nm, "_wr_data"}, bus.mem_wr_data, dat);
    endtask

    initial begin
        int snap;
        int guard;
        for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'h0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_wr_en", {28'h0, bus.mem_wr_en}, 32'h0);
        rst_n = 1'b1;

        // Aligned store word
        do_req(1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        @(negedge clk); chk_mem("sw10_acc0", 32'h10, 4'hF, 32'hDEADBEEF);

        // Byte store, then loads with each extension flavour
        do_req(2, 1'b1, F3_B, 32'h13, 32'h000000A5, 32'h0, 1'b0, 2, 1'b1);
        @(negedge clk); chk_mem("sb13_acc0", 32'h10, 4'h8, 32'hA5000000);
        do_req(3, 1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 1'b1);
        do_req(4, 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000A5, 1'b0, 2, 1'b1);
        do_req(5, 1'b0, F3_W,  32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 2, 1'b1);
        do_req(6, 1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFA5AD, 1'b0, 2, 1'b1);
        do_req(7, 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000A5AD, 1'b0, 2, 1'b1);

        // Word-crossing store and loads
        do_req(8, 1'b1, F3_W, 32'h1E, 32'h11223344, 32'h0, 1'b0, 3, 1'b1);
        @(negedge clk); chk_mem("sw1e_acc0", 32'h1C, 4'hC, 32'h33440000);
        @(negedge clk); chk_mem("sw1e_acc1", 32'h20, 4'h3, 32'h00001122);
        do_req(9,  1'b0, F3_W, 32'h1E, 32'h0, 32'h11223344, 1'b0, 3, 1'b1);
        do_req(10, 1'b0, F3_H, 32'h1F, 32'h0, 32'h00002233, 1'b0, 3, 1'b1);
        do_req(11, 1'b0, F3_B, 32'h1F, 32'h0, 32'h00000033, 1'b0, 2, 1'b1);

        // Range boundary and illegal codes: no memory activity allowed
        @(posedge clk); #1 snap = en_cnt;
        do_req(12, 1'b0, F3_H, 32'h7F, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        do_req(13, 1'b1, F3_H, 32'h7F, 32'h0000BBCC, 32'h0, 1'b1, 1, 1'b1);
        do_req(14, 1'b0, F3_B, 32'h80, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        do_req(15, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        @(negedge clk); chk("illegal_ld_ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk); chk("illegal_ld_ready_after", {31'h0, bus.req_ready}, 32'h1);
        do_req(16, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1);
        @(negedge clk); chk("illegal_st_ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk); chk("illegal_st_ready_after", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1 chk("err_no_write_cycles", 32'(en_cnt - snap), 32'h0);
        chk("mem_7c_untouched", mword(32'h7C), 32'h0);
        chk("mem_10_untouched", mword(32'h10), 32'hA5ADBEEF);
        do_req(17, 1'b0, F3_W, 32'h7C, 32'h0, 32'h0, 1'b0, 2, 1'b1);

        // Reset in the middle of a split store
        do_req(18, 1'b1, F3_W, 32'h1E, 32'hAABBCCDD, 32'h0, 1'b0, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_wr_en", {28'h0, bus.mem_wr_en}, 32'h0);
        chk("rst_mid_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_mid_word20", mword(32'h20), 32'h00001122);
        chk("rst_mid_word1c", mword(32'h1C), 32'h33440000);

        do_req(19, 1'b1, F3_W, 32'h10, 32'h12345678, 32'h0, 1'b0, 2, 1'b1);
        @(negedge clk); chk_mem("sw10b_acc0", 32'h10, 4'hF, 32'h12345678);
        do_req(20, 1'b0, F3_W, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, 1'b1);

        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        repeat (2) @(negedge clk);
        chk("mem_10_final", mword(32'h10), 32'h12345678);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit directly upstream of the byte-enabled data memory.
- Accepts one load or store request at a time from the execute stage and drives the memory's write address, write data, 4-bit byte write enable and read address.
- Handles byte, half and word sizes, sign and zero extension, and misaligned accesses that cross a word boundary (split into two memory accesses).
- Returns a one-cycle response with the load data or an error flag.

Parameters:
- MEM_BYTES, 128, size of the data memory in bytes; any accessed byte at or above this address is out of range.
- AW, 32, request address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal funct3 or out-of-range access.
- mem_wr_addr  out  32  word-aligned write address to memory.
- mem_wr_data  out  32  lane-shifted store data.
- mem_wr_en  out  4  byte-lane write enables.
- mem_rd_addr  out  32  word-aligned read address.
- mem_rd_data  in  32  combinational read data from memory.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Reset (async, rst_n=0) forces IDLE; all registered outputs clear to 0.
- Memory-side outputs are combinational from state, so mem_wr_en becomes 0 immediately when reset asserts.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/funct3/addr/wdata.
  - Compute off=addr[1:0] and size mask m = 1 / 3 / F for byte / half / word.
  - Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Illegal code, or last byte (addr + bytes - 1) >= MEM_BYTES → go to RESP with err=1. No memory access and no partial write.
  - Otherwise go to ACC0.
- ACC0:
  - mem_wr_addr = mem_rd_addr = {addr[AW-1:2],2'b00}.
  - Byte mask M8 = m << off (8 bits).
  - Store: mem_wr_en = M8[3:0]; mem_wr_data = wdata << 8*off.
  - Load: capture (mem_rd_data >> 8*off) into the raw holding register.
  - If M8[7:4] != 0 → ACC1, else → RESP.
- ACC1:
  - Address = ACC0 address + 4.
  - Store: mem_wr_en = M8[7:4]; mem_wr_data = wdata >> 8*(4-off).
  - Load: OR (mem_rd_data << 8*(4-off)) into raw.
  - → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Load data is raw masked to size, then sign-extended (000, 001) or zero-extended (010, 100, 101).
  - → IDLE.
- Outside ACC0/ACC1, mem_wr_en=0 and both addresses are 0.
- Latency, counting request accept at edge T: aligned or non-crossing access → rsp_valid in cycle T+2; crossing access → T+3; error → T+1.
- req_ready=0 from ACC0 through RESP. rsp_valid and req_ready are never both high.
- The response has no backpressure; the consumer must take it in the pulse cycle.
- Reset mid-operation: the in-flight request is dropped. A split store interrupted after ACC0 leaves only its first half written.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t;
  - the size-to-mask function.
- One natural sub-module: lsu_load_extend, purely combinational: raw[31:0] plus funct3 in, extended rdata out.

Test Plan:
- Store-word aligned: reset released, SW addr 0x10 data 0xDEADBEEF → ACC0 drives mem_wr_addr 0x10, mem_wr_en 4'hF, mem_wr_data 0xDEADBEEF; rsp_valid at T+2 with err 0, rdata 0.
- Byte store and load extension: SB 0x13 data 0x000000A5 → mem_wr_en 4'b1000, mem_wr_data 0xA5000000; then LB 0x13 → rsp_rdata 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- Misaligned word store and load: SW 0x1E data 0x11223344 → ACC0 addr 0x1C, en 4'b1100, data 0x33440000; ACC1 addr 0x20, en 4'b0011, data 0x00001122; then LW 0x1E → rsp_rdata 0x11223344 at T+3.
- Out of range: LH 0x7F with MEM_BYTES=128 → rsp_valid at T+1, rsp_err 1, rsp_rdata 0, mem_wr_en never nonzero. SH 0x7F → same, and no write occurs.
- Illegal code: load funct3 3'b011, and store funct3 3'b100 → rsp_err 1, no memory access, req_ready back to 1 the cycle after the response.
- Reset mid-split: assert rst_n=0 during ACC0 of SW 0x1E → mem_wr_en drops to 0 at once, word 0x20 unchanged, no rsp_valid; after release req_ready=1 and a new SW 0x10 completes normally.
